// File: rtl/countdown_timer_bcd.sv
// Microwave cook timer: keypad digits shift into an MM:SS BCD register, then the
// value counts down once per TICK_DIV clocks, with done pulse and held beep.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | accepting keypad digits, waiting for start
// S_RUN   | magnetron on, prescaler running, decrement on each tick
// S_PAUSE | door opened or stop pressed while running; all frozen
// S_DONE  | reached 00:00, beep held until stop or any key
module countdown_timer_bcd #(
  parameter int TICK_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done,
  output logic       beep
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      min_tens_q, min_tens_d;
  logic [3:0]      min_ones_q, min_ones_d;
  logic [3:0]      sec_tens_q, sec_tens_d;
  logic [3:0]      sec_ones_q, sec_ones_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            running_q, done_q, beep_q;

  logic [3:0]      dec_mt, dec_mo, dec_st, dec_so;
  logic            borrow_so, borrow_st, borrow_mo;
  logic            time_zero, dec_zero;

  // BCD decrement chain; seconds tens borrows to 5 but otherwise counts down
  // from whatever was entered, so 0:90 runs 90, 89, ...
  always_comb begin
    borrow_so = (sec_ones_q == 4'd0);
    borrow_st = borrow_so && (sec_tens_q == 4'd0);
    borrow_mo = borrow_st && (min_ones_q == 4'd0);

    dec_so = borrow_so ? 4'd9 : sec_ones_q - 4'd1;
    dec_st = sec_tens_q;
    if (borrow_so) dec_st = (sec_tens_q == 4'd0) ? 4'd5 : sec_tens_q - 4'd1;
    dec_mo = min_ones_q;
    if (borrow_st) dec_mo = (min_ones_q == 4'd0) ? 4'd9 : min_ones_q - 4'd1;
    dec_mt = min_tens_q;
    if (borrow_mo && (min_tens_q != 4'd0)) dec_mt = min_tens_q - 4'd1;

    time_zero = ({min_tens_q, min_ones_q, sec_tens_q, sec_ones_q} == 16'h0000);
    dec_zero  = ({dec_mt, dec_mo, dec_st, dec_so} == 16'h0000);
  end

  always_comb begin
    state_d    = state_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    presc_d    = presc_q;

    case (state_q)
      S_IDLE: begin
        if (stop) begin
          min_tens_d = 4'd0;
          min_ones_d = 4'd0;
          sec_tens_d = 4'd0;
          sec_ones_d = 4'd0;
        end else if (start) begin
          if (door_closed && !time_zero) begin
            state_d = S_RUN;
            presc_d = '0;
          end
        end else if (key_valid && (key_code <= 4'd9)) begin
          min_tens_d = min_ones_q;
          min_ones_d = sec_tens_q;
          sec_tens_d = sec_ones_q;
          sec_ones_d = key_code;
        end
      end

      S_RUN: begin
        if (stop || !door_closed) begin
          state_d = S_PAUSE;
        end else if (presc_q == PRESC_LAST) begin
          presc_d    = '0;
          min_tens_d = dec_mt;
          min_ones_d = dec_mo;
          sec_tens_d = dec_st;
          sec_ones_d = dec_so;
          if (dec_zero) state_d = S_DONE;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      S_PAUSE: begin
        if (stop) begin
          state_d    = S_IDLE;
          min_tens_d = 4'd0;
          min_ones_d = 4'd0;
          sec_tens_d = 4'd0;
          sec_ones_d = 4'd0;
        end else if (start && door_closed) begin
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        if (stop || key_valid) begin
          state_d    = S_IDLE;
          min_tens_d = 4'd0;
          min_ones_d = 4'd0;
          sec_tens_d = 4'd0;
          sec_ones_d = 4'd0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
      presc_q    <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      beep_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      presc_q    <= presc_d;
      running_q  <= (state_d == S_RUN);
      done_q     <= (state_d == S_DONE) && (state_q != S_DONE);
      beep_q     <= (state_d == S_DONE);
    end
  end

  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign running  = running_q;
  assign done     = done_q;
  assign beep     = beep_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed bench for countdown_timer_bcd with TICK_DIV=4: a vector table for
// entry/run/pause basics plus hand sequences for borrow, completion, door and reset.
module tb_countdown_timer_bcd;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       door_closed = 1'b1;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, done, beep;

  int total = 0;
  int bad = 0;

  countdown_timer_bcd #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .start(start), .stop(stop), .door_closed(door_closed),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .done(done), .beep(beep)
  );

  always #5 clk = ~clk;

  wire [18:0] obs = {min_tens, min_ones, sec_tens, sec_ones, running, done, beep};

  typedef struct {
    logic        kv;
    logic [3:0]  kc;
    logic        st;
    logic        sp;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[18];

  function automatic logic [18:0] ev(input int mt, input int mo, input int st, input int so,
                                     input logic r, input logic d, input logic b);
    return {4'(mt), 4'(mo), 4'(st), 4'(so), r, d, b};
  endfunction

  function automatic vec_t mk(input logic kv, input logic [3:0] kc, input logic st,
                              input logic sp, input logic [18:0] e);
    vec_t v;
    v.kv = kv; v.kc = kc; v.st = st; v.sp = sp; v.exp = e;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic chk(input string nm, input logic [18:0] act, input logic [18:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got mm:ss/r/d/b=%h expected %h", nm, act, exp);
    end
  endtask

  task automatic key(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    step();
    key_valid = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic press_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 4'd1,  1'b0, 1'b0, ev(0, 0, 0, 1, 0, 0, 0));
    vecs[1]  = mk(1'b1, 4'd3,  1'b0, 1'b0, ev(0, 0, 1, 3, 0, 0, 0));
    vecs[2]  = mk(1'b1, 4'd12, 1'b0, 1'b0, ev(0, 0, 1, 3, 0, 0, 0));
    vecs[3]  = mk(1'b1, 4'd0,  1'b0, 1'b0, ev(0, 1, 3, 0, 0, 0, 0));
    vecs[4]  = mk(1'b0, 4'd0,  1'b1, 1'b0, ev(0, 1, 3, 0, 1, 0, 0));
    vecs[5]  = mk(1'b1, 4'd5,  1'b0, 1'b0, ev(0, 1, 3, 0, 1, 0, 0));
    vecs[6]  = mk(1'b0, 4'd0,  1'b0, 1'b0, ev(0, 1, 3, 0, 1, 0, 0));
    vecs[7]  = mk(1'b0, 4'd0,  1'b0, 1'b0, ev(0, 1, 3, 0, 1, 0, 0));
    vecs[8]  = mk(1'b0, 4'd0,  1'b0, 1'b0, ev(0, 1, 2, 9, 1, 0, 0));
    vecs[9]  = mk(1'b0, 4'd0,  1'b1, 1'b1, ev(0, 1, 2, 9, 0, 0, 0));
    vecs[10] = mk(1'b0, 4'd0,  1'b1, 1'b0, ev(0, 1, 2, 9, 1, 0, 0));
    vecs[11] = mk(1'b0, 4'd0,  1'b0, 1'b0, ev(0, 1, 2, 9, 1, 0, 0));
    vecs[12] = mk(1'b0, 4'd0,  1'b0, 1'b0, ev(0, 1, 2, 9, 1, 0, 0));
    vecs[13] = mk(1'b0, 4'd0,  1'b0, 1'b0, ev(0, 1, 2, 9, 1, 0, 0));
    vecs[14] = mk(1'b0, 4'd0,  1'b0, 1'b0, ev(0, 1, 2, 8, 1, 0, 0));
    vecs[15] = mk(1'b0, 4'd0,  1'b0, 1'b1, ev(0, 1, 2, 8, 0, 0, 0));
    vecs[16] = mk(1'b0, 4'd0,  1'b0, 1'b1, ev(0, 0, 0, 0, 0, 0, 0));
    vecs[17] = mk(1'b0, 4'd0,  1'b1, 1'b0, ev(0, 0, 0, 0, 0, 0, 0));

    steps(2);
    rst_n = 1'b1;
    chk("reset_state", obs, ev(0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 18; i++) begin
      key_valid = vecs[i].kv;
      key_code  = vecs[i].kc;
      start     = vecs[i].st;
      stop      = vecs[i].sp;
      step();
      chk($sformatf("vec%0d", i), obs, vecs[i].exp);
    end
    key_valid = 1'b0; start = 1'b0; stop = 1'b0;

    // 01:30 down to 00:59 after 31 ticks, then reset while running
    key(4'd1); key(4'd3); key(4'd0);
    press_start();
    chk("run_start", obs, ev(0, 1, 3, 0, 1, 0, 0));
    steps(4);
    chk("run_tick1", obs, ev(0, 1, 2, 9, 1, 0, 0));
    steps(4 * 30);
    chk("run_tick31", obs, ev(0, 0, 5, 9, 1, 0, 0));
    rst_n = 1'b0;
    #2;
    chk("reset_async", obs, ev(0, 0, 0, 0, 0, 0, 0));
    step();
    rst_n = 1'b1;
    chk("reset_held", obs, ev(0, 0, 0, 0, 0, 0, 0));
    press_start();
    chk("start_zero_after_reset", obs, ev(0, 0, 0, 0, 0, 0, 0));

    // borrow chain with oldest digit dropped
    key(4'd9); key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    chk("shift_drop", obs, ev(1, 0, 0, 0, 0, 0, 0));
    press_start();
    steps(3);
    chk("borrow_pre", obs, ev(1, 0, 0, 0, 1, 0, 0));
    step();
    chk("borrow_tick", obs, ev(0, 9, 5, 9, 1, 0, 0));
    press_stop(); press_stop();
    chk("borrow_clear", obs, ev(0, 0, 0, 0, 0, 0, 0));

    // seconds above 59 count literally
    key(4'd9); key(4'd0);
    press_start();
    steps(4);
    chk("sec90_tick", obs, ev(0, 0, 8, 9, 1, 0, 0));
    press_stop(); press_stop();

    // completion, done pulse, held beep, stop exit
    key(4'd0); key(4'd2);
    key(4'd12);
    chk("invalid_key", obs, ev(0, 0, 0, 2, 0, 0, 0));
    press_start();
    steps(4);
    chk("done_tick1", obs, ev(0, 0, 0, 1, 1, 0, 0));
    steps(3);
    chk("done_pre", obs, ev(0, 0, 0, 1, 1, 0, 0));
    step();
    chk("done_entry", obs, ev(0, 0, 0, 0, 0, 1, 1));
    step();
    chk("done_pulse_end", obs, ev(0, 0, 0, 0, 0, 0, 1));
    steps(5);
    chk("beep_held", obs, ev(0, 0, 0, 0, 0, 0, 1));
    press_start();
    chk("done_start_ignored", obs, ev(0, 0, 0, 0, 0, 0, 1));
    press_stop();
    chk("done_stop", obs, ev(0, 0, 0, 0, 0, 0, 0));

    // key exits DONE without being shifted in
    key(4'd1);
    press_start();
    steps(4);
    chk("done2_entry", obs, ev(0, 0, 0, 0, 0, 1, 1));
    key(4'd7);
    chk("done_key_exit", obs, ev(0, 0, 0, 0, 0, 0, 0));

    // door open at 00:45 with prescaler mid-phase
    key(4'd4); key(4'd5);
    press_start();
    steps(2);
    door_closed = 1'b0;
    step();
    chk("door_pause", obs, ev(0, 0, 4, 5, 0, 0, 0));
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("door_frozen%0d", i), obs, ev(0, 0, 4, 5, 0, 0, 0));
    end
    press_start();
    chk("door_open_start", obs, ev(0, 0, 4, 5, 0, 0, 0));
    door_closed = 1'b1;
    press_start();
    chk("door_resume", obs, ev(0, 0, 4, 5, 1, 0, 0));
    step();
    chk("phase_hold", obs, ev(0, 0, 4, 5, 1, 0, 0));
    step();
    chk("phase_tick", obs, ev(0, 0, 4, 4, 1, 0, 0));
    press_stop(); press_stop();
    chk("final_clear", obs, ev(0, 0, 0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
